ha_array_mul_seq: RTL and testbench

HA_ARRAY_MUL_SEQ -- requirements
Module: ha_array_mul_seq

---
 rtl/ha_array_mul_seq.sv | 107 ++++++++++
 tb/tb_ha_array_mul_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ha_array_mul_seq.sv
// Purpose: approximate 8x8 unsigned multiplier that accumulates four external half-adder array rows.
// Latency: 4 cycles from the accept edge to out_valid, independent of the operands.
// Backpressure: the product holds in DONE until out_ready; a new pair is accepted on the handoff edge.
//
// Ports:
//   clk, rst_n             clock and synchronous active-low reset
//   in_valid/in_ready      operand handshake, in_x/in_y unsigned 8-bit operands
//   arr_x/arr_y            registered operands driven to the external partial-product array
//   arr_t0..3/arr_b0..3    per-row sum (weight i) and carry (weight i+2) vectors from that array
//   out_valid/out_ready    product handshake, out_p 16-bit approximate product
//   busy                   high whenever the block is not idle
module ha_array_mul_seq #(
    parameter logic [15:0] BIAS = 16'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_x,
    input  logic [7:0]  in_y,
    output logic [7:0]  arr_x,
    output logic [7:0]  arr_y,
    input  logic [6:0]  arr_b0,
    input  logic [6:0]  arr_b1,
    input  logic [6:0]  arr_b2,
    input  logic [6:0]  arr_b3,
    input  logic [8:0]  arr_t0,
    input  logic [8:0]  arr_t1,
    input  logic [8:0]  arr_t2,
    input  logic [8:0]  arr_t3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_p,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [1:0]  cnt;
    logic [15:0] acc;
    logic [8:0]  row_t;
    logic [6:0]  row_b;
    logic [15:0] row_val;
    logic [15:0] acc_sum;
    logic        accept;

    // in_ready is gated by rst_n so nothing looks acceptable while reset is held.
    assign in_ready  = rst_n & ((state == S_IDLE) | ((state == S_DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    // Select the row addressed by cnt; rows are consumed strictly in order 0..3.
    always_comb begin
        row_t = arr_t0;
        row_b = arr_b0;
        case (cnt)
            2'd1: begin row_t = arr_t1; row_b = arr_b1; end
            2'd2: begin row_t = arr_t2; row_b = arr_b2; end
            2'd3: begin row_t = arr_t3; row_b = arr_b3; end
            default: ;
        endcase
    end

    // Carry bit i sits two places above sum bit i within the row; row k carries weight 4^k.
    assign row_val = {7'd0, row_t} + {7'd0, row_b, 2'b00};
    assign acc_sum = acc + (row_val << {cnt, 1'b0});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 2'd0;
            acc   <= 16'd0;
            arr_x <= 8'd0;
            arr_y <= 8'd0;
            out_p <= 16'd0;
        end else begin
            case (state)
                S_ACC: begin
                    acc <= acc_sum;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state <= S_DONE;
                        out_p <= acc_sum;
                    end
                end
                S_IDLE, S_DONE: begin
                    // In DONE an accept doubles as the product handoff.
                    if (accept) begin
                        arr_x <= in_x;
                        arr_y <= in_y;
                        acc   <= BIAS;
                        cnt   <= 2'd0;
                        state <= S_ACC;
                    end else if ((state == S_DONE) && out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ha_array_mul_seq.sv
module tb_ha_array_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  in_x;
    logic [7:0]  in_y;

    // Instance 0: BIAS = 0; instance 1: BIAS = 16'hFFF0 (wrap-around). Both share stimulus.
    logic        d0_in_ready, d0_out_valid, d0_busy;
    logic [7:0]  d0_arr_x, d0_arr_y;
    logic [15:0] d0_out_p;
    logic [6:0]  d0_b0, d0_b1, d0_b2, d0_b3;
    logic [8:0]  d0_t0, d0_t1, d0_t2, d0_t3;
    logic        d1_in_ready, d1_out_valid, d1_busy;
    logic [7:0]  d1_arr_x, d1_arr_y;
    logic [15:0] d1_out_p;
    logic [6:0]  d1_b0, d1_b1, d1_b2, d1_b3;
    logic [8:0]  d1_t0, d1_t1, d1_t2, d1_t3;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    // Stand-in for the external half-adder array: row k adds x*y[2k] and (x*y[2k+1])<<1 with
    // half adders. Approximations: x0y3 is eliminated, x0y4 is moved into row 0 carry bit 3
    // (weight 5) and OR-merged with the carry already there.
    function automatic logic [15:0] ha_row(input logic [7:0] x, input logic [7:0] y, input int k);
        logic [8:0] a, b, t, c;
        logic [6:0] bv;
        a = {1'b0, x & {8{y[2*k]}}};
        b = {x & {8{y[2*k+1]}}, 1'b0};
        if (k == 1) b[1] = 1'b0;
        if (k == 2) a[0] = 1'b0;
        t  = a ^ b;
        c  = a & b;
        bv = c[7:1];
        if (k == 0) bv[3] = bv[3] | (x[0] & y[4]);
        return {bv, t};
    endfunction

    // Product the block must report: BIAS + sum over k of (t_k + 4*b_k) * 4^k, modulo 2^16.
    function automatic logic [15:0] golden(input logic [7:0] x, input logic [7:0] y, input logic [15:0] bias);
        logic [31:0] sum;
        logic [15:0] r;
        sum = {16'd0, bias};
        for (int k = 0; k < 4; k++) begin
            r   = ha_row(x, y, k);
            sum = sum + ((32'(r[8:0]) + (32'(r[15:9]) << 2)) << (2 * k));
        end
        return sum[15:0];
    endfunction

    assign {d0_b0, d0_t0} = ha_row(d0_arr_x, d0_arr_y, 0);
    assign {d0_b1, d0_t1} = ha_row(d0_arr_x, d0_arr_y, 1);
    assign {d0_b2, d0_t2} = ha_row(d0_arr_x, d0_arr_y, 2);
    assign {d0_b3, d0_t3} = ha_row(d0_arr_x, d0_arr_y, 3);
    assign {d1_b0, d1_t0} = ha_row(d1_arr_x, d1_arr_y, 0);
    assign {d1_b1, d1_t1} = ha_row(d1_arr_x, d1_arr_y, 1);
    assign {d1_b2, d1_t2} = ha_row(d1_arr_x, d1_arr_y, 2);
    assign {d1_b3, d1_t3} = ha_row(d1_arr_x, d1_arr_y, 3);

    ha_array_mul_seq #(.BIAS(16'd0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d0_in_ready),
        .in_x(in_x), .in_y(in_y), .arr_x(d0_arr_x), .arr_y(d0_arr_y),
        .arr_b0(d0_b0), .arr_b1(d0_b1), .arr_b2(d0_b2), .arr_b3(d0_b3),
        .arr_t0(d0_t0), .arr_t1(d0_t1), .arr_t2(d0_t2), .arr_t3(d0_t3),
        .out_valid(d0_out_valid), .out_ready(out_ready), .out_p(d0_out_p), .busy(d0_busy)
    );

    ha_array_mul_seq #(.BIAS(16'hFFF0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d1_in_ready),
        .in_x(in_x), .in_y(in_y), .arr_x(d1_arr_x), .arr_y(d1_arr_y),
        .arr_b0(d1_b0), .arr_b1(d1_b1), .arr_b2(d1_b2), .arr_b3(d1_b3),
        .arr_t0(d1_t0), .arr_t1(d1_t1), .arr_t2(d1_t2), .arr_t3(d1_t3),
        .out_valid(d1_out_valid), .out_ready(out_ready), .out_p(d1_out_p), .busy(d1_busy)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: m_age counts edges since the accept (1..4 accumulating, 5 = product held).
    int          m_age = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  m_x = 8'd0;
    logic [7:0]  m_y = 8'd0;
    bit          m_acc_edge = 1'b0;
    bit          m_rst_edge = 1'b0;
    bit          m_rdy;
    int          n_acc = 0;
    int          n_out = 0;
    int          dut_out = 0;

    always @(posedge clk) begin
        m_rdy      = rst_n && (m_age == 0 || (m_age == 5 && out_ready));
        m_acc_edge = m_rdy && in_valid;
        m_rst_edge = !rst_n;
        if (rst_n && d0_out_valid && out_ready) dut_out++;
        if (!rst_n) begin
            m_age = 0;
            exp_q.delete();
            m_x = 8'd0;
            m_y = 8'd0;
        end else begin
            if (m_age == 5 && out_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                n_out++;
                m_age = 0;
            end else if (m_age >= 1 && m_age <= 4) begin
                m_age++;
            end
            if (m_acc_edge) begin
                exp_q.push_back(golden(in_x, in_y, 16'd0));
                m_x = in_x;
                m_y = in_y;
                n_acc++;
                m_age = 1;
            end
        end
    end

    // Per-cycle comparison on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic exp_rdy;
        exp_rdy = rst_n && (m_age == 0 || (m_age == 5 && out_ready));
        chk("in_ready0", d0_in_ready, exp_rdy);
        chk("in_ready1", d1_in_ready, exp_rdy);
        chk("out_valid0", d0_out_valid, m_age == 5);
        chk("out_valid1", d1_out_valid, m_age == 5);
        chk("busy0", d0_busy, m_age != 0);
        chk("busy1", d1_busy, m_age != 0);
        chk("arr_x0", d0_arr_x, m_x);
        chk("arr_y0", d0_arr_y, m_y);
        chk("arr_x1", d1_arr_x, m_x);
        chk("arr_y1", d1_arr_y, m_y);
        if (m_age == 5) begin
            if (exp_q.size() == 0) begin
                chk("model_queue_empty", 16'd1, 16'd0);
            end else begin
                chk("out_p0", d0_out_p, exp_q[0]);
                chk("out_p1", d1_out_p, exp_q[0] + 16'hFFF0);
            end
        end
        if (m_rst_edge) begin
            chk("rst_out_p0", d0_out_p, 16'd0);
            chk("rst_out_p1", d1_out_p, 16'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a pair and hold it until accepted (bounded).
    task automatic offer(input logic [7:0] x, input logic [7:0] y);
        bit got;
        got = 1'b0;
        in_x = x;
        in_y = y;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            step();
            got = m_acc_edge;
        end
        if (!got) chk("accept_timeout", 16'd0, 16'd1);
        in_valid = 1'b0;
    endtask

    // One operation with out_ready high; checks fixed latency and literal products.
    task automatic run_one(input string name, input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp0);
        out_ready = 1'b1;
        offer(x, y);
        for (int i = 1; i <= 3; i++) begin
            chk({name, "_early_valid"}, d0_out_valid, 1'b0);
            chk({name, "_busy"}, d0_busy, 1'b1);
            step();
        end
        step();
        chk({name, "_valid_at_4"}, d0_out_valid, 1'b1);
        chk({name, "_p0"}, d0_out_p, exp0);
        chk({name, "_p1"}, d1_out_p, exp0 + 16'hFFF0);
        step();
        chk({name, "_idle"}, d0_busy, 1'b0);
    endtask

    initial begin
        bit ok;
        int acc_start;
        int cycles;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_x = 8'd0;
        in_y = 8'd0;

        chk("model_2x3", golden(8'd2, 8'd3, 16'd0), 16'd6);
        chk("model_1x16", golden(8'd1, 8'd16, 16'd0), 16'd32);
        chk("model_1x8", golden(8'd1, 8'd8, 16'd0), 16'd0);
        chk("model_9x10", golden(8'd9, 8'd10, 16'd0), 16'd82);
        chk("model_255", golden(8'd255, 8'd255, 16'd0), 16'hFDE9);
        chk("model_255_bias", golden(8'd255, 8'd255, 16'hFFF0), 16'hFDD9);

        repeat (3) step();
        rst_n = 1'b1;
        chk("reset_busy", d0_busy, 1'b0);
        chk("reset_out_p", d0_out_p, 16'd0);

        run_one("p2x3", 8'd2, 8'd3, 16'd6);
        run_one("p1x16", 8'd1, 8'd16, 16'd32);
        run_one("p1x8", 8'd1, 8'd8, 16'd0);

        // Stall in DONE with a new pair on offer, then handoff and accept on one edge.
        out_ready = 1'b0;
        offer(8'd5, 8'd6);
        repeat (4) step();
        chk("stall_valid", d0_out_valid, 1'b1);
        in_x = 8'd9;
        in_y = 8'd10;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_in_ready", d0_in_ready, 1'b0);
            chk("stall_out_p", d0_out_p, 16'd30);
            chk("stall_arr_x", d0_arr_x, 8'd5);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("handoff_accept", d0_arr_x, 8'd9);
        chk("handoff_valid", d0_out_valid, 1'b0);
        chk("handoff_busy", d0_busy, 1'b1);
        repeat (4) step();
        chk("handoff_p", d0_out_p, 16'd82);
        step();

        // Reset pulse while accumulating row 2: operation is aborted without a product.
        offer(8'd7, 8'd9);
        repeat (2) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_valid", d0_out_valid, 1'b0);
        chk("abort_busy", d0_busy, 1'b0);
        chk("abort_out_p", d0_out_p, 16'd0);
        chk("abort_arr_x", d0_arr_x, 8'd0);
        chk("abort_arr_y", d0_arr_y, 8'd0);
        run_one("p255", 8'd255, 8'd255, 16'hFDE9);

        // Random stream; the compare process checks every cycle against the model.
        acc_start = n_acc;
        cycles = 0;
        in_valid = 1'b0;
        while ((n_acc - acc_start) < 1000 && cycles < 30000) begin
            if (!in_valid && $urandom_range(0, 9) != 0) begin
                in_valid = 1'b1;
                in_x = 8'($urandom);
                in_y = 8'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            cycles++;
            if (m_acc_edge) in_valid = 1'b0;
        end
        ok = (n_acc - acc_start) >= 1000;
        chk("random_stream_done", 16'(ok), 16'd1);

        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();
        chk("out_count", 16'(dut_out), 16'(n_out));
        chk("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_err);
        $fatal(1, "watchdog");
    end

endmodule
